// File: rtl/ct_rtu_scan_encode_64_pkg.sv
// Shared RTU constants, scan-encoder state encoding and the 6-to-64 one-hot expander.
package ct_rtu_scan_encode_64_pkg;

   localparam int ENTRY_NUM   = 64;
   localparam int ENTRY_IDX_W = 6;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_e;

   // One-hot expansion of an entry index, shared with the rest of RTU.
   function automatic logic [ENTRY_NUM-1:0] rtuExpand6to64(input logic [ENTRY_IDX_W-1:0] idx);
      logic [ENTRY_NUM-1:0] onehot;
      onehot      = '0;
      onehot[idx] = 1'b1;
      return onehot;
   endfunction

endpackage

// File: rtl/ct_rtu_scan_encode_64_prio_enc.sv
// Combinational 64-to-6 priority encoder with selectable scan direction and single-bit detect.
module ct_rtu_prio_enc_64
   import ct_rtu_scan_encode_64_pkg::*;
(
   input  logic [ENTRY_NUM-1:0]   vec_i,
   input  logic                   lsb_first_i,
   output logic [ENTRY_IDX_W-1:0] idx_o,
   output logic                   single_o
);

   // The last match in loop order wins, so each loop walks toward its preferred end.
   always_comb begin
      idx_o = '0;
      if (lsb_first_i) begin
         for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = ENTRY_IDX_W'(i);
         end
      end else begin
         for (int i = 0; i < ENTRY_NUM; i++) begin
            if (vec_i[i]) idx_o = ENTRY_IDX_W'(i);
         end
      end
   end

   assign single_o = (vec_i != '0) && ((vec_i & (vec_i - ENTRY_NUM'(1))) == '0);

endmodule

// File: rtl/ct_rtu_scan_encode_64.sv
// Serialises a 64-entry vector into a stream of set-bit indices with a valid/ready handshake.
module ct_rtu_scan_encode_64
   import ct_rtu_scan_encode_64_pkg::*;
#(
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                   forever_cpuclk,
   input  logic                   cpurst_b,
   input  logic                   x_load_vld,
   input  logic [ENTRY_NUM-1:0]   x_load_vec,
   output logic                   x_load_rdy,
   input  logic                   x_flush,
   output logic                   x_num_vld,
   output logic [ENTRY_IDX_W-1:0] x_num,
   output logic                   x_num_last,
   input  logic                   x_num_rdy,
   output logic                   x_done,
   output logic                   x_busy
);

   scan_state_e            state_q;
   logic [ENTRY_NUM-1:0]   mask_q;
   logic [ENTRY_NUM-1:0]   mask_d;
   logic                   done_q;
   logic [ENTRY_IDX_W-1:0] encIdx;
   logic                   encSingle;

   ct_rtu_prio_enc_64 u_prio_enc (
      .vec_i       (mask_q),
      .lsb_first_i (LSB_FIRST),
      .idx_o       (encIdx),
      .single_o    (encSingle)
   );

   assign mask_d = mask_q & ~rtuExpand6to64(encIdx);

   // Flush has priority over both load and handshake, and suppresses the completion pulse.
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state_q <= IDLE;
         mask_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (x_flush) begin
            state_q <= IDLE;
            mask_q  <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (x_load_vld) begin
                     mask_q <= x_load_vec;
                     if (x_load_vec == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        state_q <= SCAN;
                     end
                  end
               end
               SCAN: begin
                  if (x_num_rdy) begin
                     mask_q <= mask_d;
                     if (encSingle) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  mask_q  <= '0;
               end
            endcase
         end
      end
   end

   assign x_busy     = (state_q == SCAN);
   assign x_load_rdy = (state_q == IDLE);
   assign x_num_vld  = x_busy;
   assign x_num      = x_busy ? encIdx : '0;
   assign x_num_last = x_busy & encSingle;
   assign x_done     = done_q;

endmodule

// File: tb/tb_ct_rtu_scan_encode_64.sv
// Random and directed bench for both scan directions against a queue-based model.
module tb_ct_rtu_scan_encode_64;

   logic        clk = 1'b0;
   logic        rstB;
   logic        loadVld;
   logic [63:0] loadVec;
   logic        flush;
   logic        numRdy;

   logic        loadRdyL, numVldL, numLastL, doneL, busyL;
   logic [5:0]  numL;
   logic        loadRdyH, numVldH, numLastH, doneH, busyH;
   logic [5:0]  numH;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   int qL[$];
   int qH[$];
   bit mBusy = 1'b0;
   bit mDone = 1'b0;

   always #5 clk = ~clk;

   ct_rtu_scan_encode_64 #(.LSB_FIRST(1'b1)) dutL (
      .forever_cpuclk (clk),
      .cpurst_b       (rstB),
      .x_load_vld     (loadVld),
      .x_load_vec     (loadVec),
      .x_load_rdy     (loadRdyL),
      .x_flush        (flush),
      .x_num_vld      (numVldL),
      .x_num          (numL),
      .x_num_last     (numLastL),
      .x_num_rdy      (numRdy),
      .x_done         (doneL),
      .x_busy         (busyL)
   );

   ct_rtu_scan_encode_64 #(.LSB_FIRST(1'b0)) dutH (
      .forever_cpuclk (clk),
      .cpurst_b       (rstB),
      .x_load_vld     (loadVld),
      .x_load_vec     (loadVec),
      .x_load_rdy     (loadRdyH),
      .x_flush        (flush),
      .x_num_vld      (numVldH),
      .x_num          (numH),
      .x_num_last     (numLastH),
      .x_num_rdy      (numRdy),
      .x_done         (doneH),
      .x_busy         (busyH)
   );

   task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the clock edge, settle past it.
   task automatic applyStimulus(input bit r, input bit lv, input logic [63:0] vec,
                                input bit rdy, input bit fl);
      bit doneNext;
      rstB    = r;
      loadVld = lv;
      loadVec = vec;
      numRdy  = rdy;
      flush   = fl;
      @(posedge clk);
      doneNext = 1'b0;
      if (!r || fl) begin
         qL.delete();
         qH.delete();
         mBusy = 1'b0;
      end else if (!mBusy) begin
         if (lv) begin
            for (int i = 0; i < 64; i++) if (vec[i]) qL.push_back(i);
            for (int i = 63; i >= 0; i--) if (vec[i]) qH.push_back(i);
            if (qL.size() == 0) doneNext = 1'b1;
            else mBusy = 1'b1;
         end
      end else if (rdy) begin
         void'(qL.pop_front());
         void'(qH.pop_front());
         if (qL.size() == 0) begin
            mBusy    = 1'b0;
            doneNext = 1'b1;
         end
      end
      mDone = doneNext;
      #1;
   endtask

   task automatic checkOutput(input string tag);
      int expL;
      int expH;
      bit expLast;
      expL    = mBusy ? qL[0] : 0;
      expH    = mBusy ? qH[0] : 0;
      expLast = mBusy && (qL.size() == 1);
      compare({tag, ".loadRdyL"}, 64'(loadRdyL), 64'(!mBusy));
      compare({tag, ".vldL"},     64'(numVldL),  64'(mBusy));
      compare({tag, ".numL"},     64'(numL),     64'(expL));
      compare({tag, ".lastL"},    64'(numLastL), 64'(expLast));
      compare({tag, ".doneL"},    64'(doneL),    64'(mDone));
      compare({tag, ".busyL"},    64'(busyL),    64'(mBusy));
      compare({tag, ".loadRdyH"}, 64'(loadRdyH), 64'(!mBusy));
      compare({tag, ".vldH"},     64'(numVldH),  64'(mBusy));
      compare({tag, ".numH"},     64'(numH),     64'(expH));
      compare({tag, ".lastH"},    64'(numLastH), 64'(expLast));
      compare({tag, ".doneH"},    64'(doneH),    64'(mDone));
      compare({tag, ".busyH"},    64'(busyH),    64'(mBusy));
   endtask

   task automatic cyc(input string tag, input bit r, input bit lv, input logic [63:0] vec,
                      input bit rdy, input bit fl);
      applyStimulus(r, lv, vec, rdy, fl);
      checkOutput(tag);
   endtask

   initial begin
      logic [63:0] v;
      rstB = 1'b0; loadVld = 1'b0; loadVec = '0; flush = 1'b0; numRdy = 1'b0;

      cyc("reset0", 0, 0, 64'h0, 1, 0);
      cyc("reset1", 0, 1, 64'hFF, 1, 0);

      // Three-bit vector, consumer always ready.
      cyc("t1.load", 1, 1, 64'h8000_0000_0000_0011, 1, 0);
      for (int i = 0; i < 4; i++) cyc($sformatf("t1.c%0d", i), 1, 0, 64'h0, 1, 0);
      // Explicit spot checks on the known drain order.
      compare("t1.afterDoneRdyL", 64'(loadRdyL), 64'd1);

      // Empty vector: done pulse only.
      cyc("t3.load", 1, 1, 64'h0, 1, 0);
      compare("t3.doneL", 64'(doneL), 64'd1);
      cyc("t3.c0", 1, 0, 64'h0, 1, 0);
      cyc("t3.c1", 1, 0, 64'h0, 1, 0);

      // Stalled consumer.
      cyc("t4.load", 1, 1, 64'hF, 0, 0);
      compare("t4.firstNumH", 64'(numH), 64'd3);
      for (int i = 0; i < 3; i++) cyc($sformatf("t4.stall%0d", i), 1, 0, 64'h0, 0, 0);
      for (int i = 0; i < 5; i++) cyc($sformatf("t4.drain%0d", i), 1, 0, 64'h0, 1, 0);

      // Flush after two handshakes, colliding with a load request.
      cyc("t5.load", 1, 1, 64'hFF, 1, 0);
      cyc("t5.hs0", 1, 0, 64'h0, 1, 0);
      cyc("t5.hs1", 1, 0, 64'h0, 1, 0);
      cyc("t5.flush", 1, 1, 64'hFFFF, 1, 1);
      compare("t5.flushVldL", 64'(numVldL), 64'd0);
      cyc("t5.idle", 1, 0, 64'h0, 1, 0);
      cyc("t5.reload", 1, 1, 64'h1, 1, 0);
      compare("t5.lastH", 64'(numLastH), 64'd1);
      cyc("t5.r0", 1, 0, 64'h0, 1, 0);
      cyc("t5.r1", 1, 0, 64'h0, 1, 0);

      // Reset mid-scan, then a full 64-entry drain.
      cyc("t6.load", 1, 1, '1, 1, 0);
      for (int i = 0; i < 5; i++) cyc($sformatf("t6.pre%0d", i), 1, 0, 64'h0, 1, 0);
      cyc("t6.rst", 0, 0, 64'h0, 1, 0);
      cyc("t6.idle", 1, 0, 64'h0, 1, 0);
      cyc("t6.reload", 1, 1, '1, 1, 0);
      for (int i = 0; i < 65; i++) cyc($sformatf("t6.d%0d", i), 1, 0, 64'h0, 1, 0);

      // Random traffic: mixed densities, stalls, flushes, occasional reset.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0: v = '0;
            1: v = 64'h1 << $urandom_range(0, 63);
            2: v = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            default: v = {$urandom, $urandom};
         endcase
         cyc($sformatf("rnd%0d", n), $urandom_range(0, 99) != 0, 1'($urandom_range(0, 1)), v,
             $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
